// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the fetch stage: opcodes,
// register-index width and 2-bit branch counter encodings.
package mips_pkg;

    localparam int MIPS_RFIDX_WIDTH = 5;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_cnt_e;

    function automatic bht_cnt_e bht_next(input bht_cnt_e c,
                                          input logic taken);
        bht_cnt_e n;
        if (taken)
            n = (c == ST) ? ST : bht_cnt_e'(c + 2'd1);
        else
            n = (c == SNT) ? SNT : bht_cnt_e'(c - 2'd1);
        return n;
    endfunction

endpackage

// File: rtl/mips_if_bht.sv
// Bimodal branch history table: combinational read port,
// synchronous saturating update port.
module mips_if_bht
    import mips_pkg::*;
#(
    parameter int         DEPTH = 64,
    parameter int         IDX_W = $clog2(DEPTH),
    parameter logic [1:0] INIT  = 2'b01
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_cnt_e   cnt [DEPTH];
    logic [1:0] rd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                cnt[i] <= bht_cnt_e'(INIT);
        end else if (upd) begin
            cnt[upd_idx] <= bht_next(cnt[upd_idx], upd_taken);
        end
    end

    // read sees the pre-update value on a same-index collision
    assign rd_cnt   = cnt[rd_idx];
    assign rd_taken = rd_cnt[1];

endmodule

// File: rtl/mips_if_minidec.sv
// Fetch-side pre-decoder: register indices, jump/branch
// classification and the two static target addresses.
module mips_if_minidec
    import mips_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]           inst,
    input  logic [ADDR_W-1:0]           pc_incr,
    output logic [MIPS_RFIDX_WIDTH-1:0] rs_idx,
    output logic [MIPS_RFIDX_WIDTH-1:0] rt_idx,
    output logic                        is_jmp,
    output logic                        is_bxx,
    output logic [ADDR_W-1:0]           j_target,
    output logic [ADDR_W-1:0]           b_target
);

    logic [5:0] op;

    assign op     = inst[31:26];
    assign rs_idx = inst[25:21];
    assign rt_idx = inst[20:16];

    always_comb begin
        is_jmp = 1'b0;
        is_bxx = 1'b0;
        unique case (1'b1)
            (op == OP_J),
            (op == OP_JAL):    is_jmp = 1'b1;
            (op == OP_REGIMM),
            (op == OP_BEQ),
            (op == OP_BNE),
            (op == OP_BLEZ),
            (op == OP_BGTZ):   is_bxx = 1'b1;
            default: ;
        endcase
    end

    // jr/jalr fall through as not-taken; EX redirects them
    assign j_target = {pc_incr[ADDR_W-1:28], inst[25:0], 2'b00};
    assign b_target = pc_incr
                    + {{(ADDR_W-18){inst[15]}}, inst[15:0], 2'b00};

endmodule

// File: rtl/mips_if_dynbp.sv
// MIPS fetch stage with bimodal prediction, stall, EX
// redirect/flush and a registered IF/ID bundle.
module mips_if_dynbp
    import mips_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                BHT_DEPTH = 64,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [1:0]        BHT_INIT  = 2'b01
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic                        ex_redirect,
    input  logic [ADDR_W-1:0]           ex_redirect_pc,
    input  logic                        ex_bht_upd,
    input  logic [ADDR_W-1:0]           ex_bht_pc,
    input  logic                        ex_bht_taken,
    output logic                        I_read,
    output logic                        I_write,
    output logic [ADDR_W-3:0]           I_addr,
    output logic [DATA_W-1:0]           I_wdata,
    input  logic [DATA_W-1:0]           I_rdata,
    output logic                        if2id_valid,
    output logic [DATA_W-1:0]           if2id_inst,
    output logic [ADDR_W-1:0]           if2id_pc_incr,
    output logic                        if2id_prdt_taken,
    output logic [MIPS_RFIDX_WIDTH-1:0] if2id_rs_idx,
    output logic [MIPS_RFIDX_WIDTH-1:0] if2id_rt_idx
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [ADDR_W-1:0]           pc_r;
    logic [ADDR_W-1:0]           pc_incr;
    logic [ADDR_W-1:0]           pc_nxt;
    logic [ADDR_W-1:0]           j_target;
    logic [ADDR_W-1:0]           b_target;
    logic [MIPS_RFIDX_WIDTH-1:0] rs_idx;
    logic [MIPS_RFIDX_WIDTH-1:0] rt_idx;
    logic                        is_jmp;
    logic                        is_bxx;
    logic                        bht_taken;
    logic                        prdt;
    logic                        unused_pc;

    assign I_read  = rst_n & ~stall;
    assign I_write = 1'b0;
    assign I_wdata = '0;
    assign I_addr  = pc_r[ADDR_W-1:2];
    assign pc_incr = pc_r + ADDR_W'(4);

    assign unused_pc = ^{ex_bht_pc[ADDR_W-1:IDX_W+2],
                         ex_bht_pc[1:0]};

    mips_if_minidec #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_minidec (
        .inst     (I_rdata),
        .pc_incr  (pc_incr),
        .rs_idx   (rs_idx),
        .rt_idx   (rt_idx),
        .is_jmp   (is_jmp),
        .is_bxx   (is_bxx),
        .j_target (j_target),
        .b_target (b_target)
    );

    mips_if_bht #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W),
        .INIT  (BHT_INIT)
    ) u_bht (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_idx    (pc_r[IDX_W+1:2]),
        .rd_taken  (bht_taken),
        .upd       (ex_bht_upd),
        .upd_idx   (ex_bht_pc[IDX_W+1:2]),
        .upd_taken (ex_bht_taken)
    );

    assign prdt = is_jmp | (is_bxx & bht_taken);

    always_comb begin
        pc_nxt = pc_incr;
        priority case (1'b1)
            ex_redirect:          pc_nxt = ex_redirect_pc;
            stall:                pc_nxt = pc_r;
            is_jmp:               pc_nxt = j_target;
            (is_bxx & bht_taken): pc_nxt = b_target;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_r <= RESET_PC;
        else
            pc_r <= pc_nxt;
    end

    // redirect wins over stall: the slot becomes a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if2id_valid      <= 1'b0;
            if2id_inst       <= '0;
            if2id_pc_incr    <= '0;
            if2id_prdt_taken <= 1'b0;
            if2id_rs_idx     <= '0;
            if2id_rt_idx     <= '0;
        end else if (ex_redirect) begin
            if2id_valid      <= 1'b0;
        end else if (!stall) begin
            if2id_valid      <= 1'b1;
            if2id_inst       <= I_rdata;
            if2id_pc_incr    <= pc_incr;
            if2id_prdt_taken <= prdt;
            if2id_rs_idx     <= rs_idx;
            if2id_rt_idx     <= rt_idx;
        end
    end

endmodule
